// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and constants for the round-robin arbiter.
//   rr_state_t          - arbiter FSM state (IDLE / GRANT)
//   RR_DEFAULT_MAX_HOLD - default grant time limit when timeouts are built in
//   rr_idx_w()          - width of a requester index for N requesters
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } rr_state_t;

  localparam int unsigned RR_DEFAULT_MAX_HOLD = 16;

  // Index width for n requesters; never below 1 so a 1-bit index still exists.
  function automatic int unsigned rr_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req     [N-1:0]  request vector
//   ptr     [IW-1:0] highest-priority index (always < N)
//   winner  [IW-1:0] first set req bit searching upward from ptr, wrapping at N
//   any_req          high when any req bit is set (winner is 0 otherwise)
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned IW = rr_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  // One extra bit so ptr + offset (at most 2N-2) cannot overflow before the wrap.
  logic [IW:0] cand;

  assign any_req = |req;

  // Walk offsets from the far end back to ptr so the nearest set bit is the
  // last assignment and therefore wins.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IW + 1)'(i);
      if (cand >= (IW + 1)'(N)) begin
        cand = cand - (IW + 1)'(N);
      end
      if (req[cand[IW-1:0]]) begin
        winner = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot grant, grant hold
// until release and rotating priority.
//   clk, rst_n          clock, asynchronous active-low reset
//   req   [N-1:0]       requester i holds req[i] high while it wants/owns the resource
//   done                single-cycle release strobe from the current owner
//   gnt   [N-1:0]       registered one-hot grant, zero when idle
//   gnt_idx [IW-1:0]    binary index of the owner; holds last value when idle
//   gnt_valid           OR of gnt
//   timeout             one-cycle pulse when a grant is force-released
// Build option: define RR_ARB_TIMEOUT_EN to limit each grant to MAX_HOLD
// cycles; without it no hold counter exists and timeout is tied to 0.
//
// Handshake: a requester raises req[i] and keeps it high; ownership starts on
// the cycle after the edge where gnt[i] rises and lasts until the owner pulses
// done or drops req[i] (or the hold limit expires). Either release is taken
// at the next edge, gnt then drops, and at least one idle cycle separates any
// two grants. Other req bits are not looked at while a grant is active.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = RR_DEFAULT_MAX_HOLD,
  localparam int unsigned IW      = rr_idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid,
  output logic          timeout
);

  if (N < 2 || MAX_HOLD < 1) begin : g_bad_param
    $error("rr_arbiter: N must be >= 2 and MAX_HOLD >= 1");
  end

  rr_state_t     state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_idx_q, gnt_idx_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic [IW-1:0] winner;
  logic          any_req;
  logic          hold_expired;
  logic          release_now;

  rr_pick #(.N(N)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  // hold_q counts the cycles the current grant has been visible (1 on the
  // first cycle), so the limit is reached on the MAX_HOLD-th cycle.
  assign hold_expired = (state_q == GRANT) && (hold_q == HW'(MAX_HOLD));
  assign timeout      = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    release_now = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = GRANT;
          gnt_d       = {{(N-1){1'b0}}, 1'b1} << winner;
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d      = HW'(1);
`endif
        end
      end
      GRANT: begin
        // All release causes fold into one release, so ptr moves once.
        release_now = done || !req[gnt_idx_q] || hold_expired;
        if (release_now) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          // Explicit wrap so non-power-of-two N never yields an index >= N.
          ptr_d       = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + IW'(1);
`ifdef RR_ARB_TIMEOUT_EN
          hold_d      = '0;
          // Only a pure time-limit release is reported as a timeout.
          timeout_d   = hold_expired && !done && req[gnt_idx_q];
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_d      = hold_q + HW'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q      <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed and randomized checks of rr_arbiter, with an N=8
// (MAX_HOLD=4) instance and an N=5 (MAX_HOLD=6) instance on one clock.
// A behavioural model tracks owner, priority pointer and hold time per
// instance using plain integer arithmetic.
module tb_rr_arbiter;

`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUTs ----------------
  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;
  logic [4:0] req5;
  logic       done5;
  logic [4:0] gnt5;
  logic [2:0] gnt_idx5;
  logic       gnt_valid5;
  logic       timeout5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter #(.N(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  rr_arbiter #(.N(5), .MAX_HOLD(6)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .done(done5),
    .gnt(gnt5), .gnt_idx(gnt_idx5), .gnt_valid(gnt_valid5), .timeout(timeout5)
  );

  int n_checks;
  int n_pass;
  logic [2:0] exp_q[$];

  // ---------------- reference model ----------------
  int m_owner[2];   // -1 when idle
  int m_last[2];
  int m_ptr[2];
  int m_hold[2];
  bit m_to[2];
  int m_n[2]  = '{8, 5};
  int m_mh[2] = '{4, 6};

  function automatic int pick(input logic [7:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(p + k) % n]) return (p + k) % n;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1; m_last[i] = 0; m_ptr[i] = 0; m_hold[i] = 0; m_to[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input int i, input logic [7:0] r, input logic d);
    bit expired;
    bit rel;
    m_to[i] = 1'b0;
    if (m_owner[i] < 0) begin
      if (r != 8'd0) begin
        m_owner[i] = pick(r, m_ptr[i], m_n[i]);
        m_last[i]  = m_owner[i];
        m_hold[i]  = 1;
      end
    end else begin
      expired = TO_EN && (m_hold[i] == m_mh[i]);
      rel     = d || !r[m_owner[i]] || expired;
      if (rel) begin
        m_to[i]    = expired && !d && r[m_owner[i]];
        m_ptr[i]   = (m_owner[i] + 1) % m_n[i];
        m_owner[i] = -1;
      end else begin
        m_hold[i]++;
      end
    end
  endtask

  function automatic logic [12:0] exp8();
    logic [7:0] g;
    g = 8'd0;
    if (m_owner[0] >= 0) g[m_owner[0]] = 1'b1;
    return {g, 3'(m_last[0]), (m_owner[0] >= 0), m_to[0]};
  endfunction

  function automatic logic [9:0] exp5();
    logic [4:0] g;
    g = 5'd0;
    if (m_owner[1] >= 0) g[m_owner[1]] = 1'b1;
    return {g, 3'(m_last[1]), (m_owner[1] >= 0), m_to[1]};
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs are applied, the next rising edge is taken, and the model steps
  // with the same inputs; returns 1 time unit after the edge.
  task automatic tick_all(input logic [7:0] r8, input logic d8,
                          input logic [4:0] r5, input logic d5);
    req = r8; done = d8; req5 = r5; done5 = d5;
    @(posedge clk);
    model_edge(0, r8, d8);
    model_edge(1, {3'b000, r5}, d5);
    #1;
  endtask

  task automatic tick(input logic [7:0] r8, input logic d8);
    tick_all(r8, d8, 5'd0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'd0) begin
      $display("FAIL reset_n8: got gnt=%b idx=%0d v=%b to=%b want all zero", gnt, gnt_idx, gnt_valid, timeout);
    end else n_pass++;
    n_checks++;
    if ({gnt5, gnt_idx5, gnt_valid5, timeout5} !== 10'd0) begin
      $display("FAIL reset_n5: got gnt=%b idx=%0d v=%b to=%b want all zero", gnt5, gnt_idx5, gnt_valid5, timeout5);
    end else n_pass++;
    rst_n = 1'b1;
    model_reset();
    tick(8'd0, 1'b0);
    n_checks++;
    if ({gnt, gnt_valid} !== 9'd0) begin
      $display("FAIL idle_no_req: got gnt=%b v=%b want 0", gnt, gnt_valid);
    end else n_pass++;
  endtask

  task automatic test_basic_grant();
    tick(8'b0000_1000, 1'b0);
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'b0000_1000, 3'd3, 1'b1}) begin
      $display("FAIL basic_grant: got gnt=%b idx=%0d v=%b want gnt=00001000 idx=3 v=1", gnt, gnt_idx, gnt_valid);
    end else n_pass++;
    tick(8'b0000_1000, 1'b1);
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid} !== {8'd0, 3'd3, 1'b0}) begin
      $display("FAIL basic_release: got gnt=%b idx=%0d v=%b want gnt=0 idx=3 v=0", gnt, gnt_idx, gnt_valid);
    end else n_pass++;
    tick(8'd0, 1'b1);
    n_checks++;
    if ({gnt, gnt_valid} !== 9'd0) begin
      $display("FAIL done_in_idle: got gnt=%b v=%b want 0", gnt, gnt_valid);
    end else n_pass++;
  endtask

  task automatic test_rotation();
    logic [2:0] want [4];
    want = '{3'd4, 3'd5, 3'd7, 3'd0};
    for (int g = 0; g < 4; g++) begin
      tick(8'b1011_0001, 1'b0);
      n_checks++;
      if ({gnt_idx, gnt_valid} !== {want[g], 1'b1} || gnt !== (8'd1 << want[g])) begin
        $display("FAIL rotation[%0d]: got gnt=%b idx=%0d v=%b want idx=%0d", g, gnt, gnt_idx, gnt_valid, want[g]);
      end else n_pass++;
      tick(8'b1011_0001, 1'b1);
    end
    tick(8'd0, 1'b0);
  endtask

  task automatic test_fairness();
    logic [7:0] seen;
    logic [2:0] e;
    do_reset();
    seen = 8'd0;
    for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
    for (int i = 0; i < 8; i++) begin
      tick(8'hFF, 1'b0);
      e = exp_q.pop_front();
      n_checks++;
      if ({gnt_idx, gnt_valid} !== {e, 1'b1} || gnt !== (8'd1 << e)) begin
        $display("FAIL fairness_grant[%0d]: got gnt=%b idx=%0d v=%b want idx=%0d", i, gnt, gnt_idx, gnt_valid, e);
      end else n_pass++;
      if (gnt_valid) seen[gnt_idx] = 1'b1;
      tick(8'hFF, 1'b1);
      n_checks++;
      if ({gnt, gnt_valid} !== 9'd0) begin
        $display("FAIL fairness_idle_gap[%0d]: got gnt=%b v=%b want 0", i, gnt, gnt_valid);
      end else n_pass++;
    end
    n_checks++;
    if (seen !== 8'hFF) begin
      $display("FAIL fairness_coverage: got seen=%b want 11111111", seen);
    end else n_pass++;
  endtask

  task automatic test_withdraw();
    tick(8'b0000_0100, 1'b0);
    n_checks++;
    if ({gnt_idx, gnt_valid} !== {3'd2, 1'b1}) begin
      $display("FAIL withdraw_grant: got idx=%0d v=%b want idx=2 v=1", gnt_idx, gnt_valid);
    end else n_pass++;
    tick(8'd0, 1'b0);
    n_checks++;
    if ({gnt, gnt_valid} !== 9'd0) begin
      $display("FAIL withdraw_release: got gnt=%b v=%b want 0", gnt, gnt_valid);
    end else n_pass++;
    // Bits 2 and 3 requesting: idx 3 only if ptr moved to 3.
    tick(8'b0000_1100, 1'b0);
    n_checks++;
    if ({gnt_idx, gnt_valid} !== {3'd3, 1'b1}) begin
      $display("FAIL withdraw_ptr: got idx=%0d v=%b want idx=3 v=1", gnt_idx, gnt_valid);
    end else n_pass++;
    // done and request drop together: one release, ptr to 4.
    tick(8'd0, 1'b1);
    tick(8'b0011_0000, 1'b0);
    n_checks++;
    if ({gnt_idx, gnt_valid} !== {3'd4, 1'b1}) begin
      $display("FAIL single_advance: got idx=%0d v=%b want idx=4 v=1", gnt_idx, gnt_valid);
    end else n_pass++;
    tick(8'd0, 1'b1);
  endtask

  task automatic test_n5();
    do_reset();
    tick_all(8'd0, 1'b0, 5'b01000, 1'b0);
    n_checks++;
    if ({gnt5, gnt_idx5, gnt_valid5} !== {5'b01000, 3'd3, 1'b1}) begin
      $display("FAIL n5_first: got gnt=%b idx=%0d v=%b want gnt=01000 idx=3", gnt5, gnt_idx5, gnt_valid5);
    end else n_pass++;
    tick_all(8'd0, 1'b0, 5'b01000, 1'b1);
    tick_all(8'd0, 1'b0, 5'b10001, 1'b0);
    n_checks++;
    if ({gnt5, gnt_idx5, gnt_valid5} !== {5'b10000, 3'd4, 1'b1}) begin
      $display("FAIL n5_top: got gnt=%b idx=%0d v=%b want gnt=10000 idx=4", gnt5, gnt_idx5, gnt_valid5);
    end else n_pass++;
    tick_all(8'd0, 1'b0, 5'b10001, 1'b1);
    tick_all(8'd0, 1'b0, 5'b10001, 1'b0);
    n_checks++;
    if ({gnt5, gnt_idx5, gnt_valid5} !== {5'b00001, 3'd0, 1'b1}) begin
      $display("FAIL n5_wrap: got gnt=%b idx=%0d v=%b want gnt=00001 idx=0", gnt5, gnt_idx5, gnt_valid5);
    end else n_pass++;
    tick_all(8'd0, 1'b0, 5'd0, 1'b1);
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_hold();
    int cnt;
    do_reset();
    tick(8'b0000_0110, 1'b0);
    cnt = (gnt_valid && gnt_idx == 3'd1) ? 1 : 0;
    for (int c = 0; c < 30; c++) begin
      tick(8'b0000_0110, 1'b0);
      if (gnt_valid && gnt_idx == 3'd1) cnt++;
      else break;
    end
    n_checks++;
    if (cnt !== 4) begin
      $display("FAIL hold_length: got %0d cycles want 4", cnt);
    end else n_pass++;
    n_checks++;
    if ({gnt, gnt_valid, timeout} !== {8'd0, 1'b0, 1'b1}) begin
      $display("FAIL timeout_pulse: got gnt=%b v=%b to=%b want gnt=0 v=0 to=1", gnt, gnt_valid, timeout);
    end else n_pass++;
    tick(8'b0000_0110, 1'b0);
    n_checks++;
    if ({gnt_idx, gnt_valid, timeout} !== {3'd2, 1'b1, 1'b0}) begin
      $display("FAIL timeout_ptr: got idx=%0d v=%b to=%b want idx=2 v=1 to=0", gnt_idx, gnt_valid, timeout);
    end else n_pass++;
    tick(8'd0, 1'b0);
  endtask
`else
  task automatic test_hold();
    int held;
    int to_seen;
    do_reset();
    tick(8'b0000_0010, 1'b0);
    held = 0;
    to_seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (gnt === 8'b0000_0010 && gnt_valid === 1'b1) held++;
      if (timeout !== 1'b0) to_seen++;
      tick(8'b0000_0010, 1'b0);
    end
    n_checks++;
    if (held !== 25) begin
      $display("FAIL hold_forever: got %0d held cycles want 25", held);
    end else n_pass++;
    n_checks++;
    if (to_seen !== 0) begin
      $display("FAIL timeout_tied_low: got %0d timeout cycles want 0", to_seen);
    end else n_pass++;
    tick(8'b0000_0010, 1'b1);
    n_checks++;
    if ({gnt, gnt_valid} !== 9'd0) begin
      $display("FAIL hold_release: got gnt=%b v=%b want 0", gnt, gnt_valid);
    end else n_pass++;
  endtask
`endif

  task automatic test_reset_mid_grant();
    tick_all(8'b0001_0000, 1'b0, 5'b00100, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, gnt_idx, gnt_valid, timeout} !== 13'd0) begin
      $display("FAIL async_reset_n8: got gnt=%b idx=%0d v=%b to=%b want all zero", gnt, gnt_idx, gnt_valid, timeout);
    end else n_pass++;
    n_checks++;
    if ({gnt5, gnt_idx5, gnt_valid5, timeout5} !== 10'd0) begin
      $display("FAIL async_reset_n5: got gnt=%b idx=%0d v=%b to=%b want all zero", gnt5, gnt_idx5, gnt_valid5, timeout5);
    end else n_pass++;
    #1;
    rst_n = 1'b1;
    model_reset();
    // No ptr advance from the aborted grant: idx 0 wins over idx 4.
    tick(8'b0001_0001, 1'b0);
    n_checks++;
    if ({gnt_idx, gnt_valid} !== {3'd0, 1'b1}) begin
      $display("FAIL reset_no_advance: got idx=%0d v=%b want idx=0 v=1", gnt_idx, gnt_valid);
    end else n_pass++;
    tick(8'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] r8;
    logic [4:0] r5;
    r8 = 8'd0;
    r5 = 5'd0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) r8 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) r5 = 5'($urandom_range(0, 31));
      tick_all(r8, ($urandom_range(0, 3) == 0), r5, ($urandom_range(0, 3) == 0));
      n_checks++;
      if ({gnt, gnt_idx, gnt_valid, timeout} !== exp8()) begin
        $display("FAIL random_n8[%0d]: got %b want %b (gnt,idx,v,to)", c, {gnt, gnt_idx, gnt_valid, timeout}, exp8());
      end else n_pass++;
      n_checks++;
      if ({gnt5, gnt_idx5, gnt_valid5, timeout5} !== exp5() || gnt_idx5 > 3'd4) begin
        $display("FAIL random_n5[%0d]: got %b want %b (gnt,idx,v,to)", c, {gnt5, gnt_idx5, gnt_valid5, timeout5}, exp5());
      end else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    req      = 8'd0;
    done     = 1'b0;
    req5     = 5'd0;
    done5    = 1'b0;
    model_reset();
    test_reset();
    test_basic_grant();
    test_rotation();
    test_fairness();
    test_withdraw();
    test_n5();
    test_hold();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
